chunked_adder_sub: RTL
======================

Name: chunked_adder_sub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit ripple-carry adder.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, with the carry registered between slices.
- Adds a subtract mode, a signed-overflow flag and a Start/Busy/Done handshake.
- Used wherever a wide add must not close timing as one long combinational ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of slice cycles per operation.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request new operation; sampled only when Busy=0.
- Sub  input  1  0: add, 1: subtract; sampled with Start.
- A  input  WIDTH  operand A; sampled with Start.
- B  input  WIDTH  operand B; sampled with Start.
- Cin  input  1  carry-in (add) or borrow-in (sub); sampled with Start.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when results are valid.
- Sum  output  WIDTH  registered result.
- Carry  output  1  carry-out of the MSB slice (in sub mode, 1 = no borrow).
- Overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (Rst_n=0, asynchronous, takes effect immediately):
  - Busy=0, Done=0, Sum=0, Carry=0, Overflow=0.
  - Internal slice counter, operand shift registers and carry register all cleared; FSM returns to IDLE.
  - An in-flight operation is abandoned and no Done is produced.
- FSM states:
  - IDLE -> RUN on Start=1 at an edge while Busy=0.
  - RUN stays in RUN for NCHUNK edges, then returns to IDLE.
  - Done is a registered pulse, not a separate state.
- Acceptance (edge E0, Start=1, Busy=0):
  - Latch A.
  - Latch Bop = Sub ? ~B : B.
  - Set carry register = Cin ^ Sub.
  - Set Busy=1 and slice index k=0.
- Slice step (edges E1..E(NCHUNK)):
  - Add slice k of A, slice k of Bop and the carry register.
  - Store the slice sum into internal result bits [k*CHUNK +: CHUNK].
  - Update the carry register with the slice carry-out, then increment k.
  - Slice order is LSB first.
- Completion (edge E(NCHUNK)):
  - Sum <= full internal result; Carry <= MSB-slice carry-out.
  - Overflow <= carry into the MSB XOR carry out of the MSB, from the same final slice.
  - Done=1, Busy=0.
  - Done returns to 0 at the next edge.
- Arithmetic:
  - Sub=0: {Carry,Sum} = A + B + Cin.
  - Sub=1: Sum = A - B - Cin (mod 2^WIDTH), computed as A + ~B + ~Cin.
- Latency and throughput:
  - Latency is NCHUNK cycles from accepting edge to Done.
  - NCHUNK=1 gives single-cycle latency.
  - Throughput is one operation per NCHUNK+1 cycles: Start high at E(NCHUNK) is ignored because Busy is still 1 before that edge.
  - A Start in the cycle Done is high is accepted.
- Start while Busy=1 is ignored; no queuing, no error flag.
- Input stability:
  - Changes on A/B/Sub/Cin after acceptance have no effect on the in-flight operation.
- Output hold:
  - Sum/Carry/Overflow hold their values until the next completion or reset.
  - They do not change during RUN; intermediate slice results are never visible on Sum.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Reset: Rst_n low mid-RUN (after 2 slices) -> Busy, Done, Sum, Carry, Overflow all 0 immediately; no Done after Rst_n release; next Start completes normally.
- Add with carry-in: A=0x1234, B=0x0FCD, Cin=1, Sub=0 -> Done exactly 4 cycles after accept; Sum=0x2202, Carry=0, Overflow=0; Busy high for exactly 4 cycles.
- Add wrap-around: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Carry=1, Overflow=0.
  - Then A=0x7FFF, B=0x0001 -> Sum=0x8000, Carry=0, Overflow=1.
- Subtract: A=0x0005, B=0x0007, Cin=0, Sub=1 -> Sum=0xFFFE, Carry=0, Overflow=0.
  - Then A=0x8000, B=0x0001 -> Sum=0x7FFF, Carry=1, Overflow=1.
- Handshake:
  - Start held high continuously with changing operands -> only operands present at accepted edges are used; accepts spaced 5 cycles apart; Done one cycle wide each time.
  - Start asserted during RUN -> ignored and Sum unchanged until Done.
- Parameter sweep: WIDTH=8 with CHUNK=8, 4, 2 and 1, random A/B/Cin/Sub (≥1000 ops each) against a reference model -> Sum/Carry/Overflow match; latency equals NCHUNK (1, 2, 4, 8).

Source files
------------

// File: rtl/chunked_adder_sub.sv
// chunked_adder_sub: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB slice first.
// Ports:
//   Clk, Rst_n        rising-edge clock, asynchronous active-low reset
//   Start             request an operation (taken only while Busy=0)
//   Sub, A, B, Cin    operation, operands and carry/borrow-in, captured with Start
//   Busy              operation in progress
//   Done              one-cycle pulse when Sum/Carry/Overflow are updated
//   Sum, Carry        result and MSB-slice carry-out (1 = no borrow when subtracting)
//   Overflow          two's-complement signed overflow
module chunked_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
    logic             r_c;
    logic [KW-1:0]    r_k;
    logic [CHUNK-1:0] w_sa, w_sb;
    logic [CHUNK:0]   w_sum;
    logic             w_last, w_cmsb;

    assign w_sa   = r_a[int'(r_k)*CHUNK +: CHUNK];
    assign w_sb   = r_b[int'(r_k)*CHUNK +: CHUNK];
    assign w_sum  = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, r_c};
    assign w_last = r_k == KW'(NCHUNK - 1);
    // carry into the slice MSB recovered from its sum bit; this covers CHUNK=1 too
    assign w_cmsb = w_sum[CHUNK-1] ^ w_sa[CHUNK-1] ^ w_sb[CHUNK-1];
    assign Busy   = r_state == RUN;

    always_comb begin
        w_res = r_res;
        w_res[int'(r_k)*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && Start)
            w_next = RUN;
        else if (r_state == RUN && w_last)
            w_next = IDLE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_c      <= 1'b0;
            r_k      <= '0;
            Done     <= 1'b0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            Done    <= 1'b0;
            if (r_state == IDLE && Start) begin
                // subtraction as A + ~B + ~Cin, so the borrow-in folds into the carry seed
                r_a <= A;
                r_b <= Sub ? ~B : B;
                r_c <= Cin ^ Sub;
                r_k <= '0;
            end else if (r_state == RUN) begin
                r_res <= w_res;
                r_c   <= w_sum[CHUNK];
                r_k   <= w_last ? '0 : r_k + KW'(1);
                if (w_last) begin
                    Sum      <= w_res;
                    Carry    <= w_sum[CHUNK];
                    Overflow <= w_cmsb ^ w_sum[CHUNK];
                    Done     <= 1'b1;
                end
            end
        end
    end
endmodule
